// File: rtl/strassen_pkg.sv
// Shared element indexing, width helpers and bus unpack function for the Strassen 2x2 tile datapath.
package strassen_pkg;

    localparam int A00    = 0;
    localparam int A01    = 1;
    localparam int A10    = 2;
    localparam int A11    = 3;
    localparam int MAX_DW = 32;
    localparam int N_PROD = 7;

    // Products that only feed C00/C11 and therefore freeze on half beats.
    localparam logic [N_PROD-1:0] HALF_HOLD = 7'b1100001;

    function automatic int pre_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int prod_w(input int dw);
        return 2 * dw + 2;
    endfunction

    function automatic int min_out_w(input int dw);
        return 2 * dw + 4;
    endfunction

    // Extract element k of a packed 4-element bus and sign-extend it to MAX_DW bits.
    function automatic logic signed [MAX_DW-1:0] elem(input logic [4*MAX_DW-1:0] bus,
                                                      input int k, input int width);
        logic [4*MAX_DW-1:0]      sh;
        logic signed [MAX_DW-1:0] r;
        sh = bus >> (k * width);
        r  = sh[MAX_DW-1:0];
        r  = (r <<< (MAX_DW - width)) >>> (MAX_DW - width);
        return r;
    endfunction

endpackage

// File: rtl/strassen_preadd.sv
// Combinational Strassen T/S operand pre-adders with a per-product load mask for half beats.
module strassen_preadd
    import strassen_pkg::*;
#(
    parameter  int DW = 32,
    localparam int PW = DW + 1
) (
    input  logic [4*DW-1:0]      a,
    input  logic [4*DW-1:0]      b,
    input  logic                 half,
    output logic signed [PW-1:0] t [N_PROD],
    output logic signed [PW-1:0] s [N_PROD],
    output logic [N_PROD-1:0]    load_en
);

    logic [4*MAX_DW-1:0]      a_wide_s;
    logic [4*MAX_DW-1:0]      b_wide_s;
    logic signed [MAX_DW-1:0] a_elem_s;
    logic signed [MAX_DW-1:0] b_elem_s;
    logic signed [PW-1:0]     ae_s [4];
    logic signed [PW-1:0]     be_s [4];

    assign a_wide_s = (4*MAX_DW)'(a);
    assign b_wide_s = (4*MAX_DW)'(b);

    // Unpack the tiles and widen every element to the pre-add width.
    always_comb begin
        a_elem_s = {MAX_DW{1'b0}};
        b_elem_s = {MAX_DW{1'b0}};
        for (int k = 0; k < 4; k++) begin
            a_elem_s = elem(a_wide_s, k, DW);
            b_elem_s = elem(b_wide_s, k, DW);
            ae_s[k]  = PW'(a_elem_s);
            be_s[k]  = PW'(b_elem_s);
        end
    end

    // Strassen operand pairs; pre-adds cannot overflow at DW+1 bits.
    always_comb begin
        t[0] = ae_s[A00] + ae_s[A11];  s[0] = be_s[A00] + be_s[A11];
        t[1] = ae_s[A10] + ae_s[A11];  s[1] = be_s[A00];
        t[2] = ae_s[A00];              s[2] = be_s[A01] - be_s[A11];
        t[3] = ae_s[A11];              s[3] = be_s[A10] - be_s[A00];
        t[4] = ae_s[A00] + ae_s[A01];  s[4] = be_s[A11];
        t[5] = ae_s[A10] - ae_s[A00];  s[5] = be_s[A00] + be_s[A01];
        t[6] = ae_s[A01] - ae_s[A11];  s[6] = be_s[A10] + be_s[A11];
        if (half) begin
            load_en = ~HALF_HOLD;
        end else begin
            load_en = {N_PROD{1'b1}};
        end
    end

endmodule

// File: rtl/strassen_mm2x2_pipe.sv
// Three-stage Strassen 2x2 signed matrix multiplier with tile accumulation and a global ready/valid stall.
module strassen_mm2x2_pipe
    import strassen_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int OUTWIDTH  = 2 * DATAWIDTH + 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [4*DATAWIDTH-1:0] s_a,
    input  logic [4*DATAWIDTH-1:0] s_b,
    input  logic                   s_half,
    input  logic                   s_first,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [4*OUTWIDTH-1:0]  m_c
);

    localparam int DW  = DATAWIDTH;
    localparam int OW  = OUTWIDTH;
    localparam int PW  = pre_w(DATAWIDTH);
    localparam int PRW = prod_w(DATAWIDTH);

    logic                  en_s;
    logic signed [PW-1:0]  t_s [N_PROD];
    logic signed [PW-1:0]  s_s [N_PROD];
    logic [N_PROD-1:0]     load_en_s;

    logic                  v1_r, half1_r, first1_r, last1_r;
    logic signed [PW-1:0]  t_r [N_PROD];
    logic signed [PW-1:0]  s_r [N_PROD];

    logic                  v2_r, half2_r, first2_r, last2_r;
    logic signed [PRW-1:0] m_r [N_PROD];

    logic signed [OW-1:0]  acc_r [4];
    logic                  acc_open_r;
    logic                  m_valid_r;
    logic [4*OW-1:0]       m_c_r;

    logic signed [OW-1:0]  mx_s [N_PROD];
    logic signed [OW-1:0]  c_s [4];
    logic signed [OW-1:0]  sum_s [4];

    assign en_s    = !m_valid_r || m_ready;
    assign s_ready = en_s;
    assign m_valid = m_valid_r;
    assign m_c     = m_c_r;

    strassen_preadd #(.DW(DW)) u_preadd (
        .a       (s_a),
        .b       (s_b),
        .half    (s_half),
        .t       (t_s),
        .s       (s_s),
        .load_en (load_en_s)
    );

    // Stage 1: capture pre-added operands; half beats leave the diagonal-only pairs untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r     <= 1'b0;
            half1_r  <= 1'b0;
            first1_r <= 1'b0;
            last1_r  <= 1'b0;
            for (int i = 0; i < N_PROD; i++) begin
                t_r[i] <= {PW{1'b0}};
                s_r[i] <= {PW{1'b0}};
            end
        end else if (en_s) begin
            v1_r     <= s_valid;
            half1_r  <= s_half;
            first1_r <= s_first;
            last1_r  <= s_last;
            for (int i = 0; i < N_PROD; i++) begin
                if (s_valid && load_en_s[i]) begin
                    t_r[i] <= t_s[i];
                    s_r[i] <= s_s[i];
                end
            end
        end
    end

    // Stage 2: the seven signed products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r     <= 1'b0;
            half2_r  <= 1'b0;
            first2_r <= 1'b0;
            last2_r  <= 1'b0;
            for (int i = 0; i < N_PROD; i++) begin
                m_r[i] <= {PRW{1'b0}};
            end
        end else if (en_s) begin
            v2_r     <= v1_r;
            half2_r  <= half1_r;
            first2_r <= first1_r;
            last2_r  <= last1_r;
            for (int i = 0; i < N_PROD; i++) begin
                if (v1_r && !(half1_r && HALF_HOLD[i])) begin
                    m_r[i] <= t_r[i] * s_r[i];
                end
            end
        end
    end

    // Stage 3 combinational: post-adds and accumulation, wrapping in OW bits.
    always_comb begin
        for (int i = 0; i < N_PROD; i++) begin
            mx_s[i] = OW'(m_r[i]);
        end
        c_s[0] = half2_r ? {OW{1'b0}} : (mx_s[0] + mx_s[3] - mx_s[4] + mx_s[6]);
        c_s[1] = mx_s[2] + mx_s[4];
        c_s[2] = mx_s[1] + mx_s[3];
        c_s[3] = half2_r ? {OW{1'b0}} : (mx_s[0] - mx_s[1] + mx_s[2] + mx_s[5]);
        for (int k = 0; k < 4; k++) begin
            sum_s[k] = ((first2_r || !acc_open_r) ? {OW{1'b0}} : acc_r[k]) + c_s[k];
        end
    end

    // Stage 3 registers: accumulator and the held output tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_open_r <= 1'b0;
            m_valid_r  <= 1'b0;
            m_c_r      <= {(4*OW){1'b0}};
            for (int k = 0; k < 4; k++) begin
                acc_r[k] <= {OW{1'b0}};
            end
        end else if (en_s) begin
            if (v2_r && last2_r) begin
                m_valid_r  <= 1'b1;
                acc_open_r <= 1'b0;
                for (int k = 0; k < 4; k++) begin
                    m_c_r[k*OW +: OW] <= sum_s[k];
                    acc_r[k]          <= {OW{1'b0}};
                end
            end else begin
                m_valid_r <= 1'b0;
                if (v2_r) begin
                    acc_open_r <= 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        acc_r[k] <= sum_s[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_strassen_mm2x2_pipe.sv
// Scoreboard bench: plain 2x2 matrix-product reference model, random and directed beats, backpressure.
module tb_strassen_mm2x2_pipe;

    localparam int DW = 8;
    localparam int OW = 20;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [4*DW-1:0] s_a = '0;
    logic [4*DW-1:0] s_b = '0;
    logic            s_half = 1'b0;
    logic            s_first = 1'b0;
    logic            s_last = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [4*OW-1:0] m_c;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [79:0] exp_q[$];
    longint      model_acc[4];
    int          cyc = 0;
    int          stall_from = -100;
    int          stall_len = 0;
    bit          rnd_ready = 1'b0;

    always #5 clk = ~clk;

    strassen_mm2x2_pipe #(.DATAWIDTH(DW), .OUTWIDTH(OW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_a     (s_a),
        .s_b     (s_b),
        .s_half  (s_half),
        .s_first (s_first),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_c     (m_c)
    );

    function automatic longint el(input logic [31:0] v, input int k);
        logic [31:0]       t;
        logic signed [7:0] e;
        t = v >> (8 * k);
        e = t[7:0];
        return longint'(e);
    endfunction

    function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
    endfunction

    // Textbook row-by-column product; half beats keep only the off-diagonal terms.
    function automatic longint cval(input logic [31:0] a, input logic [31:0] b,
                                    input int k, input logic half);
        longint r;
        case (k)
            0:       r = half ? 64'sd0 : el(a, 0) * el(b, 0) + el(a, 1) * el(b, 2);
            1:       r = el(a, 0) * el(b, 1) + el(a, 1) * el(b, 3);
            2:       r = el(a, 2) * el(b, 0) + el(a, 3) * el(b, 2);
            default: r = half ? 64'sd0 : el(a, 2) * el(b, 1) + el(a, 3) * el(b, 3);
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [31:0] a, input logic [31:0] b,
                                input logic half, input logic first, input logic last);
        logic [79:0] e;
        if (first) begin
            for (int k = 0; k < 4; k++) model_acc[k] = 0;
        end
        for (int k = 0; k < 4; k++) model_acc[k] += cval(a, b, k, half);
        if (last) begin
            for (int k = 0; k < 4; k++) begin
                e[k*OW +: OW] = model_acc[k][OW-1:0];
                model_acc[k]  = 0;
            end
            exp_q.push_back(e);
        end
    endtask

    // Entered and left at posedge+1; holds the beat until the DUT takes it.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic half, input logic first, input logic last);
        bit took;
        int guard;
        took  = 1'b0;
        guard = 0;
        while (!took && guard < 200) begin
            #3;
            s_valid = 1'b1; s_a = a; s_b = b; s_half = half; s_first = first; s_last = last;
            #3;
            took = s_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        s_a     = $urandom();
        s_b     = $urandom();
        if (took) begin
            model_accept(a, b, half, first, last);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: beat not accepted within 200 cycles");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            s_valid = 1'b0;
            s_first = 1'($urandom_range(0, 1));
            s_last  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    // Downstream ready: forced low in a stall window, otherwise random or always high.
    initial begin : ready_drv
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (cyc >= stall_from && cyc < stall_from + stall_len) m_ready = 1'b0;
            else if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
            else m_ready = 1'b1;
        end
    end

    // Monitor: handshake rule, output stability under backpressure, in-order scoreboard.
    initial begin : monitor
        bit          held_v;
        logic [79:0] held_c;
        logic [79:0] e;
        held_v = 1'b0;
        held_c = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("s_ready_rule", 80'(s_ready), 80'(!m_valid || m_ready));
                if (held_v) begin
                    check("hold_valid", 80'(m_valid), 80'(1'b1));
                    check("hold_data", m_c, held_c);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got 0x%0h, expected no output", m_c);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", m_c, e);
                    end
                end
                held_v = m_valid && !m_ready;
                held_c = m_c;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin : stim
        logic [31:0] ma, mb, mi, neg, pos;
        int          guard;
        ma  = pack4(1, 2, 3, 4);
        mb  = pack4(5, 6, 7, 8);
        mi  = pack4(1, 0, 0, 1);
        neg = pack4(-128, -128, -128, -128);
        pos = pack4(127, 127, 127, 127);
        for (int k = 0; k < 4; k++) model_acc[k] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_m_valid", 80'(m_valid), 80'(1'b0));
        check("reset_m_c", m_c, 80'd0);
        rst_n = 1'b1;
        idle(2);

        // Single tile with latency probe: valid appears on the third edge counting the accept edge.
        send(ma, mb, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("latency_edge1", 80'(m_valid), 80'(1'b0));
        @(negedge clk);
        check("latency_edge2", 80'(m_valid), 80'(1'b0));
        @(negedge clk);
        check("latency_edge3", 80'(m_valid), 80'(1'b1));
        @(posedge clk);
        #1;

        send(ma, mb, 1'b1, 1'b1, 1'b1);
        send(ma, mb, 1'b0, 1'b1, 1'b1);
        send(ma, mb, 1'b0, 1'b1, 1'b0);
        send(mi, mi, 1'b0, 1'b0, 1'b1);
        send(neg, neg, 1'b0, 1'b1, 1'b1);
        send(neg, pos, 1'b0, 1'b1, 1'b1);
        idle(6);

        // Back-to-back stream into a 5-cycle downstream stall.
        stall_from = cyc + 2;
        stall_len  = 5;
        for (int i = 0; i < 8; i++) begin
            send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end
        idle(10);
        stall_len = 0;

        // Reset with a held result and a partial sum in flight.
        stall_from = cyc;
        stall_len  = 1000;
        send(ma, mb, 1'b0, 1'b1, 1'b1);
        send(mb, ma, 1'b0, 1'b1, 1'b0);
        send(ma, ma, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("pre_reset_valid", 80'(m_valid), 80'(1'b1));
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 80'(m_valid), 80'(1'b0));
        check("async_reset_m_c", m_c, 80'd0);
        exp_q.delete();
        for (int k = 0; k < 4; k++) model_acc[k] = 0;
        stall_len = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send(ma, mb, 1'b0, 1'b0, 1'b1);
        send(ma, mb, 1'b0, 1'b1, 1'b1);
        idle(5);

        // Random beats, random flags, random downstream readiness.
        rnd_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send($urandom(), $urandom(), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        send($urandom(), $urandom(), 1'b0, 1'b0, 1'b1);

        rnd_ready = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        idle(3);
        check("drain_queue_empty", 80'(exp_q.size()), 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
